// File: rtl/decode_pkg.sv
// Shared decode types: instruction classes, immediate formats, opcodes and the
// decoded-result struct handed whole to the register-read/execute stage.
package decode_pkg;

    typedef enum logic [3:0] {
        ICLASS_ALU_R   = 4'd0,
        ICLASS_ALU_I   = 4'd1,
        ICLASS_LOAD    = 4'd2,
        ICLASS_STORE   = 4'd3,
        ICLASS_BRANCH  = 4'd4,
        ICLASS_JAL     = 4'd5,
        ICLASS_JALR    = 4'd6,
        ICLASS_LUI     = 4'd7,
        ICLASS_AUIPC   = 4'd8,
        ICLASS_SYSTEM  = 4'd9,
        ICLASS_FENCE   = 4'd10,
        ICLASS_ILLEGAL = 4'd15
    } iclass_e;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic [4:0]  rd_idx;
        logic [4:0]  rs1_idx;
        logic [4:0]  rs2_idx;
        logic [2:0]  funct3;
        logic        funct7_5;
        logic [31:0] imm;
        iclass_e     iclass;
        logic        writes_rd;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        illegal;
    } decoded_t;

    // The alternate funct7 only selects SUB and SRA; M-extension ops ride on F7_MULDIV.
    function automatic logic rtype_legal(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic en_m);
        return (f7 == F7_BASE)
            || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)))
            || (en_m && (f7 == F7_MULDIV));
    endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Immediate generator: selects and sign-extends the immediate for one RV32I format.
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    logic [6:0] unused_opcode;
    assign unused_opcode = instr[6:0];

    always_comb begin
        imm = 32'd0;
        case (fmt)
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'd0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: captures fetch's word on an enabled pulse, decodes it on the
// following cycle and holds the registered result with a sticky completed flag.
module decode
    import decode_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enabled,
    input  logic [31:0] pc,
    input  logic [31:0] instr_raw,
    output logic        completed,
    output logic [31:0] pc_out,
    output logic [4:0]  rd_idx,
    output logic [4:0]  rs1_idx,
    output logic [4:0]  rs2_idx,
    output logic [2:0]  funct3,
    output logic        funct7_5,
    output logic [31:0] imm,
    output logic [3:0]  iclass,
    output logic        writes_rd,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        illegal
);

    // Handshake: a one-cycle enabled pulse (legal in any state) captures pc/instr_raw
    // and drops completed; the next cycle without enabled registers the result and
    // raises completed, which then holds with all outputs until the next pulse or rst.

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        completed_q, completed_d;
    decoded_t    res_q, res_d;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    iclass_e     dec_class;
    imm_fmt_e    dec_fmt;
    logic        dec_legal;
    logic        dec_rs1, dec_rs2, dec_wr;
    logic [31:0] dec_imm;
    decoded_t    dec;

    assign opcode = instr_q[6:0];
    assign f3     = instr_q[14:12];
    assign f7     = instr_q[31:25];

    imm_gen u_imm_gen (
        .instr (instr_q),
        .fmt   (dec_fmt),
        .imm   (dec_imm)
    );

    // Every listed opcode ends in 2'b11, so a compressed-style word falls to default.
    always_comb begin
        dec_class = ICLASS_ILLEGAL;
        dec_fmt   = FMT_NONE;
        dec_legal = 1'b1;
        dec_rs1   = 1'b0;
        dec_rs2   = 1'b0;
        dec_wr    = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_class = ICLASS_ALU_R;
                {dec_rs1, dec_rs2, dec_wr} = 3'b111;
                dec_legal = rtype_legal(f7, f3, ENABLE_M);
            end
            OPC_OP_IMM: begin
                dec_class = ICLASS_ALU_I;
                dec_fmt   = FMT_I;
                {dec_rs1, dec_wr} = 2'b11;
                if (f3 == 3'b001) begin
                    dec_legal = (f7 == F7_BASE);
                end else if (f3 == 3'b101) begin
                    dec_legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                end
            end
            OPC_LOAD: begin
                dec_class = ICLASS_LOAD;
                dec_fmt   = FMT_I;
                {dec_rs1, dec_wr} = 2'b11;
                dec_legal = !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
            end
            OPC_STORE: begin
                dec_class = ICLASS_STORE;
                dec_fmt   = FMT_S;
                {dec_rs1, dec_rs2} = 2'b11;
                dec_legal = (f3 < 3'b011);
            end
            OPC_BRANCH: begin
                dec_class = ICLASS_BRANCH;
                dec_fmt   = FMT_B;
                {dec_rs1, dec_rs2} = 2'b11;
                dec_legal = !((f3 == 3'b010) || (f3 == 3'b011));
            end
            OPC_JAL: begin
                dec_class = ICLASS_JAL;
                dec_fmt   = FMT_J;
                dec_wr    = 1'b1;
            end
            OPC_JALR: begin
                dec_class = ICLASS_JALR;
                dec_fmt   = FMT_I;
                {dec_rs1, dec_wr} = 2'b11;
                dec_legal = (f3 == 3'b000);
            end
            OPC_LUI: begin
                dec_class = ICLASS_LUI;
                dec_fmt   = FMT_U;
                dec_wr    = 1'b1;
            end
            OPC_AUIPC: begin
                dec_class = ICLASS_AUIPC;
                dec_fmt   = FMT_U;
                dec_wr    = 1'b1;
            end
            OPC_SYSTEM: begin
                dec_class = ICLASS_SYSTEM;
                dec_fmt   = FMT_I;
            end
            OPC_MISC_MEM: begin
                dec_class = ICLASS_FENCE;
                dec_fmt   = FMT_I;
            end
            default: dec_legal = 1'b0;
        endcase
        if (!dec_legal) begin
            dec_class = ICLASS_ILLEGAL;
            dec_fmt   = FMT_NONE;
            dec_rs1   = 1'b0;
            dec_rs2   = 1'b0;
            dec_wr    = 1'b0;
        end
        if (instr_q[11:7] == 5'd0) begin
            dec_wr = 1'b0;
        end
    end

    always_comb begin
        dec           = '0;
        dec.rd_idx    = instr_q[11:7];
        dec.rs1_idx   = instr_q[19:15];
        dec.rs2_idx   = instr_q[24:20];
        dec.funct3    = f3;
        dec.funct7_5  = instr_q[30];
        dec.imm       = dec_imm;
        dec.iclass    = dec_class;
        dec.writes_rd = dec_wr;
        dec.uses_rs1  = dec_rs1;
        dec.uses_rs2  = dec_rs2;
        dec.illegal   = !dec_legal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            instr_q     <= 32'd0;
            pc_q        <= 32'd0;
            pc_out_q    <= 32'd0;
            completed_q <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            pc_out_q    <= pc_out_d;
            completed_q <= completed_d;
            res_q       <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (enabled) begin
            state_d = ST_BUSY;
        end else if (state_q == ST_BUSY) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        instr_d     = instr_q;
        pc_d        = pc_q;
        pc_out_d    = pc_out_q;
        completed_d = completed_q;
        res_d       = res_q;
        if (enabled) begin
            instr_d     = instr_raw;
            pc_d        = pc;
            completed_d = 1'b0;
        end else if (state_q == ST_BUSY) begin
            res_d       = dec;
            pc_out_d    = pc_q;
            completed_d = 1'b1;
        end
    end

    assign completed = completed_q;
    assign pc_out    = pc_out_q;
    assign rd_idx    = res_q.rd_idx;
    assign rs1_idx   = res_q.rs1_idx;
    assign rs2_idx   = res_q.rs2_idx;
    assign funct3    = res_q.funct3;
    assign funct7_5  = res_q.funct7_5;
    assign imm       = res_q.imm;
    assign iclass    = res_q.iclass;
    assign writes_rd = res_q.writes_rd;
    assign uses_rs1  = res_q.uses_rs1;
    assign uses_rs2  = res_q.uses_rs2;
    assign illegal   = res_q.illegal;

endmodule
